// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (fetch / load-store) arbiter onto one shared memory port.
// Load/store wins by default. Fetch wins once it has lost STARVE_LIMIT collisions in a row.
// The memory-side outputs are registered. The grants are decoded combinationally in IDLE,
// so a request is granted in the same cycle it is seen.
// Optional feature: define ARB_PERF_EN to add grant and stall performance counters.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    // fetch side
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    // load/store side
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    input  logic [3:0]    ls_be,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    // shared memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]   perf_if_grants,
    output logic [31:0]   perf_ls_grants,
    output logic [31:0]   perf_stall_cycles
`endif
);

    // Wide enough to hold STARVE_LIMIT; the count saturates there.
    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_starve_cnt;
    logic            r_if_rvalid;
    logic            r_ls_rvalid;
    logic [31:0]     r_if_rdata;
    logic [31:0]     r_ls_rdata;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [3:0]      r_mem_be;

    logic            w_idle;
    logic            w_starved;
    logic            w_if_win;
    logic            w_ls_win;

    // The grants are gated by reset so that they also drop asynchronously.
    assign w_idle    = (r_state == IDLE) && reset;
    assign w_starved = (r_starve_cnt >= SW'(STARVE_LIMIT));
    assign w_if_win  = w_idle && if_req && (!ls_req || w_starved);
    assign w_ls_win  = w_idle && ls_req && !w_if_win;

    assign if_gnt    = w_if_win;
    assign ls_gnt    = w_ls_win;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

    // Arbitration FSM: latch the winner's request in IDLE, then hold it until mem_ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_if_win) begin
                        r_state     <= BUSY_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= 4'hF;
                    end else if (w_ls_win) begin
                        r_state     <= BUSY_LS;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ls_we;
                        r_mem_addr  <= ls_addr;
                        r_mem_wdata <= ls_wdata;
                        r_mem_be    <= ls_be;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        r_state     <= IDLE;
                        r_mem_req   <= 1'b0;
                        r_if_rdata  <= mem_rdata;
                        r_if_rvalid <= 1'b1;
                    end
                end
                BUSY_LS: begin
                    // A store also captures mem_rdata. That value is meaningless but harmless.
                    if (mem_ack) begin
                        r_state     <= IDLE;
                        r_mem_req   <= 1'b0;
                        r_ls_rdata  <= mem_rdata;
                        r_ls_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Count collisions lost by fetch. Any fetch grant clears the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_if_win) begin
            r_starve_cnt <= '0;
        end else if (w_ls_win && if_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] r_perf_if_grants;
    logic [31:0] r_perf_ls_grants;
    logic [31:0] r_perf_stall_cycles;

    assign perf_if_grants    = r_perf_if_grants;
    assign perf_ls_grants    = r_perf_ls_grants;
    assign perf_stall_cycles = r_perf_stall_cycles;

    // Wrapping counters. A stall cycle has some request high but no grant at all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_if_grants    <= '0;
            r_perf_ls_grants    <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (w_if_win) r_perf_if_grants <= r_perf_if_grants + 32'd1;
            if (w_ls_win) r_perf_ls_grants <= r_perf_ls_grants + 32'd1;
            if ((if_req || ls_req) && !(w_if_win || w_ls_win)) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (STARVE_LIMIT=4, AW=32).
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_ls_grants;
    logic [31:0] perf_stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .AW           (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_if_grants    (perf_if_grants),
        .perf_ls_grants    (perf_ls_grants),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0; ls_be = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        #3;
        check("rst_mem_req",  32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check("rst_starve",   32'(dut.r_starve_cnt), 32'd0);
        tick(); tick();
        #2 reset = 1'b1;
        tick();

        // Fetch only: gnt at N, mem at N+1, rvalid at N+2
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        check("s1_if_gnt", 32'(if_gnt), 32'd1);
        check("s1_ls_gnt", 32'(ls_gnt), 32'd0);
        tick();
        if_req = 1'b0;
        check("s1_mem_req",  32'(mem_req), 32'd1);
        check("s1_mem_addr", mem_addr, 32'h10);
        check("s1_mem_we",   32'(mem_we), 32'd0);
        check("s1_rvalid_early", 32'(if_rvalid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h00500113;
        tick();
        mem_ack = 1'b0;
        check("s1_if_rvalid", 32'(if_rvalid), 32'd1);
        check("s1_if_rdata",  if_rdata, 32'h00500113);
        check("s1_mem_req_drop", 32'(mem_req), 32'd0);
        tick();
        check("s1_rvalid_pulse", 32'(if_rvalid), 32'd0);
        check("s1_rdata_hold", if_rdata, 32'h00500113);

        // mem_ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_if_rvalid", 32'(if_rvalid), 32'd0);
        check("idle_ack_ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("idle_ack_mem_req",   32'(mem_req), 32'd0);
        check("idle_ack_rdata",     if_rdata, 32'h00500113);

        // Collision: the store wins, then fetch is granted on the next IDLE cycle
        if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h64; ls_wdata = 32'hDEADBEEF; ls_be = 4'hF;
        #1;
        check("s2_ls_gnt", 32'(ls_gnt), 32'd1);
        check("s2_if_gnt", 32'(if_gnt), 32'd0);
        tick();
        ls_req = 1'b0;
        #1;
        check("s2_mem_we",    32'(mem_we), 32'd1);
        check("s2_mem_addr",  mem_addr, 32'h64);
        check("s2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("s2_mem_be",    32'(mem_be), 32'hF);
        check("s2_busy_no_if_gnt", 32'(if_gnt), 32'd0);
        check("s2_starve_1",  32'(dut.r_starve_cnt), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("s2_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("s2_if_gnt_after", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0;
        check("s2_if_mem_we",   32'(mem_we), 32'd0);
        check("s2_if_mem_addr", mem_addr, 32'h20);
        check("s2_starve_clr",  32'(dut.r_starve_cnt), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b0;
        check("s2_if_rvalid", 32'(if_rvalid), 32'd1);
        check("s2_if_rdata",  if_rdata, 32'h11112222);

        // Starvation: four load grants, then fetch is forced through
        if_req = 1'b1; if_addr = 32'h30;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h90;
        mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("s3_ls_gnt_%0d", k), 32'(ls_gnt), 32'd1);
            check($sformatf("s3_if_lose_%0d", k), 32'(if_gnt), 32'd0);
            tick();
            check($sformatf("s3_busy_nognt_%0d", k), 32'(if_gnt | ls_gnt), 32'd0);
            tick();
        end
        #1;
        check("s3_starve_4",  32'(dut.r_starve_cnt), 32'd4);
        check("s3_if_forced", 32'(if_gnt), 32'd1);
        check("s3_ls_held",   32'(ls_gnt), 32'd0);
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        check("s3_starve_0",  32'(dut.r_starve_cnt), 32'd0);
        check("s3_mem_addr",  mem_addr, 32'h30);
        check("s3_mem_we",    32'(mem_we), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("s3_if_rvalid", 32'(if_rvalid), 32'd1);
        check("s3_if_rdata",  if_rdata, 32'h5555AAAA);

        // Memory wait: ack withheld for 10 cycles while a fetch waits
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
        #1;
        check("s4_ls_gnt", 32'(ls_gnt), 32'd1);
        tick();
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h34;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("s4_mem_req_%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("s4_mem_addr_%0d", i), mem_addr, 32'h80);
            check($sformatf("s4_no_gnt_%0d", i), 32'(if_gnt | ls_gnt), 32'd0);
            check($sformatf("s4_no_rvalid_%0d", i), 32'(ls_rvalid), 32'd0);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        check("s4_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("s4_ls_rdata",  ls_rdata, 32'hCAFEF00D);
        #1;
        check("s4_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0;
        check("s4_ls_rvalid_pulse", 32'(ls_rvalid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0F0F;
        tick();
        mem_ack = 1'b0;
        check("s4_if_rvalid", 32'(if_rvalid), 32'd1);
        check("s4_ls_rdata_hold", ls_rdata, 32'hCAFEF00D);

        // Reset mid-access abandons the store
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h70; ls_wdata = 32'h12345678; ls_be = 4'h3;
        #1;
        check("s5_ls_gnt", 32'(ls_gnt), 32'd1);
        tick();
        ls_req = 1'b0;
        check("s5_mem_req", 32'(mem_req), 32'd1);
        check("s5_mem_be",  32'(mem_be), 32'h3);
        #2 reset = 1'b0;
        #1;
        check("s5_async_mem_req", 32'(mem_req), 32'd0);
        check("s5_async_mem_addr", mem_addr, 32'd0);
        check("s5_async_mem_we",  32'(mem_we), 32'd0);
        check("s5_async_mem_be",  32'(mem_be), 32'd0);
        check("s5_async_if_rdata", if_rdata, 32'd0);
        check("s5_async_ls_rdata", ls_rdata, 32'd0);
        mem_ack = 1'b1;
        tick();
        check("s5_no_rvalid_rst", 32'(ls_rvalid), 32'd0);
        #2 reset = 1'b1; mem_ack = 1'b0;
        tick();
        check("s5_no_rvalid_after", 32'(ls_rvalid), 32'd0);
        check("s5_idle_mem_req",    32'(mem_req), 32'd0);
        if_req = 1'b1; if_addr = 32'h44;
        #1;
        check("s5_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0;
        check("s5_mem_addr", mem_addr, 32'h44);
        mem_ack = 1'b1; mem_rdata = 32'hABCD0001;
        tick();
        mem_ack = 1'b0;
        check("s5_if_rvalid", 32'(if_rvalid), 32'd1);
        check("s5_if_rdata",  if_rdata, 32'hABCD0001);

`ifdef ARB_PERF_EN
        // Perf counters: one collision (load wins), then 2 more fetches and 1 more load
        reset = 1'b0;
        #2 reset = 1'b1;
        tick();
        check("p_if_zero",    perf_if_grants, 32'd0);
        check("p_stall_zero", perf_stall_cycles, 32'd0);
        if_req = 1'b1; if_addr = 32'h50;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'hA0;
        mem_ack = 1'b1;
        tick();
        ls_req = 1'b0;
        tick();
        tick();
        if_req = 1'b0;
        tick();
        for (int f = 0; f < 2; f++) begin
            if_req = 1'b1;
            tick();
            if_req = 1'b0;
            tick();
        end
        ls_req = 1'b1;
        tick();
        ls_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("p_if_grants",    perf_if_grants, 32'd3);
        check("p_ls_grants",    perf_ls_grants, 32'd2);
        check("p_stall_cycles", perf_stall_cycles, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
